ws2811_encoder: RTL and testbench
=================================

// Module: ws2811_encoder
// PURPOSE
//  Re-modulates a decoded WS2811 bit stream (dataIn qualified by dataClk, as produced by the
//  satellite's WS2811 decoder) into a WS2811 one-wire waveform on dataOut for the next
//  downstream device. Sits between the decoder and the outgoing LED/satellite line.
//  Each dataClk rising edge emits one bit cell: high for T0H or T1H, then low.
//  The 50 us low reset/latch period is reproduced implicitly: dataOut stays low while no dataClk arrives.
// PARAMETERS
//  CLK_FREQ_HZ  133_000_000  masterClk frequency (OSCH nominal); used to derive all counts
//  T0H_NS       250          high time of a '0' bit (ns)
//  T1H_NS       600          high time of a '1' bit (ns)
//  TMIN_L_NS    250          minimum low time enforced between two emitted pulses (ns)
// PORTS
//  masterClk  in   1  system clock (the one clock)
//  rst        in   1  asynchronous, active-high reset
//  dataClk    in   1  bit strobe from the decoder; rising edge = dataIn valid
//  dataIn     in   1  decoded bit value, sampled on the dataClk rising edge
//  dataOut    out  1  WS2811-modulated output (idle/reset level = 0)
// BEHAVIOUR
//  - Counts: CNT_x = ceil(x_NS * CLK_FREQ_HZ / 1e9), computed at elaboration; counter width = clog2(max count + 1).
//  - Reset: dataOut=0, FSM=IDLE, counters=0, pending flag=0, sync regs=0. Async assert; release is synchronised to masterClk.
//  - Input: dataClk and dataIn each pass a 2-FF synchroniser in masterClk.
//    A rising edge is detected as sync_clk & ~sync_clk_d. dataIn is captured from its synchronised
//    copy in the same cycle as the detected edge. The decoder holds dataIn stable around the strobe.
//  - FSM states IDLE, HIGH, LOW_GUARD:
//    IDLE: on edge -> latch bit, load counter with CNT_T1H or CNT_T0H, dataOut=1 next cycle, go HIGH.
//      Latency from detected edge to dataOut rise = 1 masterClk.
//    HIGH: decrement; at 0 -> dataOut=0, load CNT_TMIN_L, go LOW_GUARD.
//    LOW_GUARD: decrement; at 0 -> if pending then start pending bit exactly as in IDLE, else IDLE.
//  - Edge arriving in HIGH or LOW_GUARD: store it in a 1-deep pending register (bit + flag).
//    A second edge while pending is already set overwrites the pending bit. This is an overrun and is not expected at nominal rates.
//  - Edge in the same cycle the guard expires: the new edge is served directly, and the pending register is left unchanged.
//  - High-time accuracy: +/-1 masterClk vs T0H/T1H. Low time is set by the upstream bit period,
//    so the cell period tracks the input (+/- MAX_SKEW tolerated by the downstream decoder).
//  - Idle/latch: no dataClk -> dataOut stays 0 indefinitely.
//  - Reset mid-pulse: dataOut drops to 0 immediately (async), and any partial bit is discarded.
// STRUCTURE
//  - Shared env package/include: OSCH_FREQ, T0H/T1H/period and MAX_SKEW constants, used by the decoder, the encoder and the benches.
//  - One sub-module: ws2811_edge_sync.
//    It contains the 2-FF sync of dataClk and dataIn, and outputs the one-cycle strobe plus the captured bit.
//  - Top: FSM, pulse counter, pending register, registered dataOut (glitch-free).
// TESTING
//  - Chain: WS2811 generator -> decoder -> ws2811_encoder -> receiving decoder. Results are shifted into a 32-bit register on the receiving decoder's dataClk.
//  - Nominal timing (T1H 600, T0H 250, period 1240 ns): bytes 55,AA,00,FF then >50 us low ->
//    receiver captures 55 AA 00 FF; receiver active=1 during bytes, active=0 after the latch.
//  - +MAX_SKEW on all input timings, same bytes -> identical capture and active behaviour.
//  - -MAX_SKEW on all input timings, same bytes -> identical capture; encoder high times remain T0H/T1H +/-1 clk.
//  - Leading garbage byte F0 followed by a latch, before the test -> no corruption of the later 55 AA 00 FF frame.
//  - 50 us idle after a frame -> dataOut constant 0, receiver active=0, result unchanged.
//  - Assert rst during a '1' high pulse -> dataOut=0 within the same time step.
//    Next frame after release decodes correctly.

Source files
------------

// File: rtl/ws2811_encoder_pkg.sv
// Shared WS2811 timing constants, encoder state type and ns-to-cycle conversion.
package ws2811_encoder_pkg;

  localparam int unsigned OSCH_FREQ   = 133_000_000;
  localparam int unsigned T0H_NS      = 250;
  localparam int unsigned T1H_NS      = 600;
  localparam int unsigned TMIN_L_NS   = 250;
  localparam int unsigned PERIOD_NS   = 1240;
  localparam int unsigned MAX_SKEW_NS = 150;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIGH,
    S_LOW_GUARD
  } enc_state_t;

  // ceil(ns * freq / 1e9), evaluated at elaboration
  function automatic int unsigned ns_to_cycles(input int unsigned ns, input int unsigned freq_hz);
    logic [63:0] prod;
    prod = 64'(ns) * 64'(freq_hz);
    return 32'((prod + 64'd999_999_999) / 64'd1_000_000_000);
  endfunction

endpackage

// File: rtl/ws2811_edge_sync.sv
// Synchronises the decoder's bit strobe and data into masterClk and emits a
// one-cycle strobe with the bit captured alongside it.
module ws2811_edge_sync (
  input  logic masterClk,
  input  logic rst,
  input  logic dataClk,
  input  logic dataIn,
  output logic dataStrobe,
  output logic dataBit
);

  logic [1:0] sync_clk;
  logic [1:0] sync_dat;
  logic       sync_clk_d;

  always_ff @(posedge masterClk or posedge rst) begin
    if (rst) begin
      sync_clk   <= 2'b00;
      sync_dat   <= 2'b00;
      sync_clk_d <= 1'b0;
      dataStrobe <= 1'b0;
      dataBit    <= 1'b0;
    end else begin
      sync_clk   <= {sync_clk[0], dataClk};
      sync_dat   <= {sync_dat[0], dataIn};
      sync_clk_d <= sync_clk[1];
      dataStrobe <= sync_clk[1] & ~sync_clk_d;
      dataBit    <= sync_dat[1];
    end
  end

endmodule

// File: rtl/ws2811_encoder.sv
// Re-modulates a decoded WS2811 bit stream into a one-wire WS2811 waveform,
// with a 1-deep pending slot for strobes that arrive while a cell is in flight.
module ws2811_encoder
  import ws2811_encoder_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = OSCH_FREQ,
  parameter int unsigned T0H_NS_P    = T0H_NS,
  parameter int unsigned T1H_NS_P    = T1H_NS,
  parameter int unsigned TMIN_L_NS_P = TMIN_L_NS
) (
  input  logic masterClk,
  input  logic rst,
  input  logic dataClk,
  input  logic dataIn,
  output logic dataOut
);

  localparam int unsigned CNT_T0H    = ns_to_cycles(T0H_NS_P, CLK_FREQ_HZ);
  localparam int unsigned CNT_T1H    = ns_to_cycles(T1H_NS_P, CLK_FREQ_HZ);
  localparam int unsigned CNT_TMIN_L = ns_to_cycles(TMIN_L_NS_P, CLK_FREQ_HZ);
  localparam int unsigned CNT_MAX01  = (CNT_T0H > CNT_T1H) ? CNT_T0H : CNT_T1H;
  localparam int unsigned CNT_MAX    = (CNT_MAX01 > CNT_TMIN_L) ? CNT_MAX01 : CNT_TMIN_L;
  localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);

  // Assert asynchronously, release two masterClk edges later
  logic [1:0] rst_pipe;
  logic       rst_int;

  always_ff @(posedge masterClk or posedge rst) begin
    if (rst) rst_pipe <= 2'b11;
    else     rst_pipe <= {rst_pipe[0], 1'b0};
  end

  assign rst_int = rst_pipe[1];

  logic strobe;
  logic strobe_bit;

  ws2811_edge_sync u_edge_sync (
    .masterClk  (masterClk),
    .rst        (rst_int),
    .dataClk    (dataClk),
    .dataIn     (dataIn),
    .dataStrobe (strobe),
    .dataBit    (strobe_bit)
  );

  enc_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             pend_valid;
  logic             pend_bit;

  // High time counts down from the loaded value and ends when it reaches 1
  always_ff @(posedge masterClk or posedge rst_int) begin
    if (rst_int) begin
      state      <= S_IDLE;
      cnt        <= '0;
      dataOut    <= 1'b0;
      pend_valid <= 1'b0;
      pend_bit   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (strobe) begin
            dataOut <= 1'b1;
            cnt     <= strobe_bit ? CNT_W'(CNT_T1H) : CNT_W'(CNT_T0H);
            state   <= S_HIGH;
          end
        end
        S_HIGH: begin
          if (strobe) begin
            pend_valid <= 1'b1;
            pend_bit   <= strobe_bit;
          end
          if (cnt <= CNT_W'(1)) begin
            dataOut <= 1'b0;
            cnt     <= CNT_W'(CNT_TMIN_L);
            state   <= S_LOW_GUARD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_LOW_GUARD: begin
          if (cnt <= CNT_W'(1)) begin
            // A fresh strobe at expiry wins and leaves the pending slot alone
            if (strobe) begin
              dataOut <= 1'b1;
              cnt     <= strobe_bit ? CNT_W'(CNT_T1H) : CNT_W'(CNT_T0H);
              state   <= S_HIGH;
            end else if (pend_valid) begin
              dataOut    <= 1'b1;
              cnt        <= pend_bit ? CNT_W'(CNT_T1H) : CNT_W'(CNT_T0H);
              pend_valid <= 1'b0;
              state      <= S_HIGH;
            end else begin
              cnt   <= '0;
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
            if (strobe) begin
              pend_valid <= 1'b1;
              pend_bit   <= strobe_bit;
            end
          end
        end
        default: begin
          dataOut <= 1'b0;
          cnt     <= '0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws2811_encoder.sv
// Bench for ws2811_encoder: drives decoded bit strobes and classifies the
// measured output pulse widths against WS2811 timing derived from nanoseconds.
`timescale 1ns / 1ps
module tb_ws2811_encoder;
  import ws2811_encoder_pkg::*;

  localparam real CLK_HALF_NS = 1.0e9 / real'(OSCH_FREQ) / 2.0;

  logic masterClk = 1'b0;
  logic rst       = 1'b1;
  logic dataClk   = 1'b0;
  logic dataIn    = 1'b0;
  logic dataOut;

  ws2811_encoder dut (
    .masterClk (masterClk),
    .rst       (rst),
    .dataClk   (dataClk),
    .dataIn    (dataIn),
    .dataOut   (dataOut)
  );

  always #(CLK_HALF_NS) masterClk = ~masterClk;

  // Reference timing in masterClk cycles, from the ns figures
  int exp_c0;
  int exp_c1;
  int exp_cl;

  int errors = 0;
  int checks = 0;

  // Pulse/gap recorder sampled on the inactive clock edge
  int widths[$];
  int gaps[$];
  int hi_cnt = 0;
  int lo_cnt = 0;
  bit seen   = 1'b0;

  always @(negedge masterClk) begin
    if (rst) begin
      hi_cnt = 0;
      lo_cnt = 0;
      seen   = 1'b0;
    end else if (dataOut === 1'b1) begin
      if (hi_cnt == 0 && seen && lo_cnt < 500) gaps.push_back(lo_cnt);
      hi_cnt++;
    end else begin
      if (hi_cnt > 0) begin
        widths.push_back(hi_cnt);
        seen   = 1'b1;
        lo_cnt = 0;
      end
      hi_cnt = 0;
      lo_cnt++;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input bit b, input real period_ns);
    dataIn = b;
    #(period_ns * 0.25);
    dataClk = 1'b1;
    #(period_ns * 0.5);
    dataClk = 1'b0;
    #(period_ns * 0.25);
  endtask

  task automatic send_bytes(input logic [31:0] frame, input int skew_ns, output bit bits[$]);
    bits.delete();
    for (int i = 31; i >= 0; i--) begin
      bits.push_back(frame[i]);
      send_bit(frame[i], real'(int'(PERIOD_NS) + skew_ns));
    end
  endtask

  // Each measured pulse must match its bit's high time to within one clock
  task automatic check_pulses(input string tag, input bit bits[$]);
    chk({tag, "_count"}, widths.size(), bits.size());
    for (int i = 0; i < bits.size(); i++) begin
      int e;
      int w;
      e = bits[i] ? exp_c1 : exp_c0;
      w = (i < widths.size()) ? widths[i] : -100;
      checks++;
      assert ((w >= e - 1) && (w <= e + 1))
      else begin
        errors++;
        $error("FAIL %s_bit%0d observed_width=%0d expected_width=%0d+/-1", tag, i, w, e);
      end
    end
  endtask

  task automatic clear_log();
    widths.delete();
    gaps.delete();
  endtask

  bit exp_bits[$];
  bit idle_bad;
  int min_gap;

  initial begin
    exp_c0 = int'($ceil(real'(T0H_NS) * real'(OSCH_FREQ) / 1.0e9));
    exp_c1 = int'($ceil(real'(T1H_NS) * real'(OSCH_FREQ) / 1.0e9));
    exp_cl = int'($ceil(real'(TMIN_L_NS) * real'(OSCH_FREQ) / 1.0e9));

    // Reset state
    #50;
    chk("reset_dataOut", int'(dataOut), 0);
    rst = 1'b0;
    #200;
    chk("post_reset_idle", int'(dataOut), 0);

    // Leading garbage byte and latch
    exp_bits.delete();
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] g;
      g = 8'hF0;
      exp_bits.push_back(g[i]);
      send_bit(g[i], real'(PERIOD_NS));
    end
    #52000;
    check_pulses("garbage", exp_bits);
    clear_log();

    // Nominal frame then 50 us idle
    send_bytes(32'h55AA00FF, 0, exp_bits);
    #2000;
    check_pulses("nominal", exp_bits);
    idle_bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      #1000;
      if (dataOut !== 1'b0) idle_bad = 1'b1;
    end
    chk("idle_low", int'(idle_bad), 0);
    chk("idle_no_pulses", widths.size(), 32);
    clear_log();

    // Skewed frames
    send_bytes(32'h55AA00FF, int'(MAX_SKEW_NS), exp_bits);
    #2000;
    check_pulses("skew_pos", exp_bits);
    #52000;
    clear_log();
    send_bytes(32'h55AA00FF, -int'(MAX_SKEW_NS), exp_bits);
    #2000;
    check_pulses("skew_neg", exp_bits);
    #52000;
    clear_log();

    // Random bits at random periods within the skew window
    exp_bits.delete();
    for (int i = 0; i < 48; i++) begin
      bit b;
      int p;
      b = 1'($urandom_range(0, 1));
      p = int'(PERIOD_NS) - int'(MAX_SKEW_NS) + int'($urandom_range(0, 2 * MAX_SKEW_NS));
      exp_bits.push_back(b);
      send_bit(b, real'(p));
    end
    #2000;
    check_pulses("random", exp_bits);
    min_gap = 1000;
    foreach (gaps[i]) if (gaps[i] < min_gap) min_gap = gaps[i];
    checks++;
    assert (min_gap >= exp_cl)
    else begin
      errors++;
      $error("FAIL random_min_low observed=%0d expected>=%0d", min_gap, exp_cl);
    end
    #52000;
    clear_log();

    // Second strobe during a '1' high pulse is held and emitted after the guard
    exp_bits.delete();
    exp_bits.push_back(1'b1);
    exp_bits.push_back(1'($urandom_range(0, 1)));
    send_bit(exp_bits[0], 200.0);
    send_bit(exp_bits[1], 200.0);
    #3000;
    check_pulses("pending", exp_bits);
    chk("pending_gap_count", gaps.size(), 1);
    if (gaps.size() > 0) begin
      checks++;
      assert (gaps[0] >= exp_cl && gaps[0] <= exp_cl + 1)
      else begin
        errors++;
        $error("FAIL pending_gap observed=%0d expected=%0d..%0d", gaps[0], exp_cl, exp_cl + 1);
      end
    end
    #52000;
    clear_log();

    // Reset in the middle of a '1' high pulse
    dataIn = 1'b1;
    #100;
    dataClk = 1'b1;
    #250;
    chk("mid_pulse_high", int'(dataOut), 1);
    rst = 1'b1;
    #0.1;
    chk("async_reset_drop", int'(dataOut), 0);
    dataClk = 1'b0;
    #300;
    rst = 1'b0;
    #500;
    chk("after_reset_idle", int'(dataOut), 0);
    clear_log();
    send_bytes(32'h55AA00FF, 0, exp_bits);
    #2000;
    check_pulses("post_reset", exp_bits);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
